// File: rtl/hilo_mul_unit.sv
// Hi/Lo register pair with an iterative radix-2 multiplier for mult/multu/madd/msub,
// plus direct mthi/mtlo writes. Busy stalls the pipeline while a multiply is in flight.
module hilo_mul_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic [2:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned W  = 32;
  localparam int unsigned PW = 64;
  localparam int unsigned CW = 5;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_MADD  = 3'b010;
  localparam logic [2:0] OP_MSUB  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC} state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [W-1:0]  mcand;
  logic [W-1:0]  mplier;
  logic          neg;
  logic [PW-1:0] p;
  logic [CW-1:0] cnt;
  logic [PW-1:0] r;
  logic [PW-1:0] hilo_next;

  // Magnitude of a two's-complement value; the most negative value maps to itself.
  function automatic logic [W-1:0] abs32(input logic [W-1:0] x);
    return x[W-1] ? (~x + W'(1)) : x;
  endfunction

  // Signed result and the new Hi/Lo value written in ACC.
  always_comb begin
    r         = neg ? (PW'(0) - p) : p;
    hilo_next = r;
    case (op_q)
      OP_MADD: hilo_next = {Hi, Lo} + r;
      OP_MSUB: hilo_next = {Hi, Lo} - r;
      default: hilo_next = r;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= S_IDLE;
      op_q   <= OP_MULT;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
      p      <= '0;
      cnt    <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Hi     <= '0;
      Lo     <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (Start && !Flush) begin
            case (Op)
              OP_MULT, OP_MADD, OP_MSUB: begin
                op_q   <= Op;
                mcand  <= abs32(A);
                mplier <= abs32(B);
                neg    <= A[W-1] ^ B[W-1];
                p      <= '0;
                cnt    <= '0;
                Busy   <= 1'b1;
                state  <= S_MUL;
              end
              OP_MULTU: begin
                op_q   <= Op;
                mcand  <= A;
                mplier <= B;
                neg    <= 1'b0;
                p      <= '0;
                cnt    <= '0;
                Busy   <= 1'b1;
                state  <= S_MUL;
              end
              OP_MTHI: begin
                Hi   <= A;
                Done <= 1'b1;
              end
              OP_MTLO: begin
                Lo   <= A;
                Done <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MUL: begin
          if (Flush) begin
            Busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            if (mcand[cnt]) p <= p + (PW'(mplier) << cnt);
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) state <= S_ACC;
          end
        end
        S_ACC: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
          if (!Flush) begin
            {Hi, Lo} <= hilo_next;
            Done     <= 1'b1;
          end
        end
        default: begin
          Busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mul_unit.sv
// Scoreboard bench for hilo_mul_unit: expected Hi/Lo pushed at issue, popped at Done.
module tb_hilo_mul_unit;

  logic        Clk, Reset, Start, Flush;
  logic [2:0]  Op;
  logic [31:0] A, B;
  logic        Busy, Done;
  logic [31:0] Hi, Lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl_hi = '0, mdl_lo = '0;
  logic [63:0] sb[$];

  hilo_mul_unit dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, b,
                                        input logic [63:0] hl);
    logic [63:0] prod;
    if (op == 3'b001) prod = {32'b0, a} * {32'b0, b};
    else prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    case (op)
      3'b000, 3'b001: return prod;
      3'b010: return hl + prod;
      3'b011: return hl - prod;
      3'b100: return {a, hl[31:0]};
      3'b101: return {hl[63:32], a};
      default: return hl;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, b, input bit track);
    logic [63:0] e;
    if (track) begin
      e = model(op, a, b, {mdl_hi, mdl_lo});
      {mdl_hi, mdl_lo} = e;
      sb.push_back(e);
    end
    Start = 1'b1; Op = op; A = a; B = b;
    @(posedge Clk);
    #1;
    Start = 1'b0; Op = 3'b111; A = '0; B = '0;
  endtask

  // Waits (bounded) for a Done pulse, counting cycles and Busy cycles on the way.
  task automatic collect(input int limit, output bit seen, output int cyc, output int bcyc,
                         output logic [31:0] hi, output logic [31:0] lo);
    seen = 0; cyc = 0; bcyc = 0; hi = '0; lo = '0;
    while (!seen && cyc < limit) begin
      @(negedge Clk);
      cyc++;
      if (Busy) bcyc++;
      if (Done) begin seen = 1; hi = Hi; lo = Lo; end
    end
  endtask

  task automatic count_dones(input int n, output int d);
    d = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      if (Done) d++;
    end
  endtask

  task automatic test_reset();
    Reset = 1'b0; Start = 1'b0; Flush = 1'b0; Op = 3'b111; A = '0; B = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({Busy, Done, Hi, Lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b hi=%h lo=%h, want all 0", Busy, Done, Hi, Lo);
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
  endtask

  task automatic test_op(input string name, input logic [2:0] op, input logic [31:0] a, b,
                         input int exp_cyc);
    bit seen; int cyc, bcyc, d; logic [31:0] hi, lo; logic [63:0] e;
    issue(op, a, b, 1);
    collect(60, seen, cyc, bcyc, hi, lo);
    e = sb.pop_front();
    checks++;
    if (!seen || cyc != exp_cyc) begin
      errors++;
      $display("FAIL %s_latency: done=%b after %0d cycles, want done=1 after %0d", name, seen, cyc, exp_cyc);
    end
    checks++;
    if ({hi, lo} !== e) begin
      errors++;
      $display("FAIL %s_result: hi/lo=%h_%h, want %h", name, hi, lo, e);
    end
    checks++;
    if (bcyc != exp_cyc - 1) begin
      errors++;
      $display("FAIL %s_busy: busy for %0d cycles, want %0d", name, bcyc, exp_cyc - 1);
    end
    count_dones(3, d);
    checks++;
    if (d != 0 || {Hi, Lo} !== e) begin
      errors++;
      $display("FAIL %s_after: extra dones=%0d hi/lo=%h_%h, want 0 and %h", name, d, Hi, Lo, e);
    end
  endtask

  task automatic test_mult();
    test_op("mult_neg", 3'b000, 32'hFFFF_FFFD, 32'd7, 34);
    checks++;
    if ({Hi, Lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      errors++;
      $display("FAIL mult_neg_const: hi/lo=%h_%h, want ffffffff_ffffffeb", Hi, Lo);
    end
    test_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    test_op("mult_min", 3'b000, 32'h8000_0000, 32'h8000_0000, 34);
    checks++;
    if ({Hi, Lo} !== 64'h4000_0000_0000_0000) begin
      errors++;
      $display("FAIL mult_min_const: hi/lo=%h_%h, want 40000000_00000000", Hi, Lo);
    end
    test_op("mult_rand", 3'b000, $urandom, $urandom, 34);
    test_op("multu_rand", 3'b001, $urandom, $urandom, 34);
  endtask

  task automatic test_madd_msub();
    test_op("mthi0", 3'b100, 32'd0, 32'd0, 1);
    test_op("mtlo100", 3'b101, 32'd100, 32'd0, 1);
    test_op("madd", 3'b010, 32'hFFFF_FFFE, 32'd5, 34);
    checks++;
    if ({Hi, Lo} !== 64'h0000_0000_0000_005A) begin
      errors++;
      $display("FAIL madd_const: hi/lo=%h_%h, want 00000000_0000005a", Hi, Lo);
    end
    test_op("mtlo0", 3'b101, 32'd0, 32'd0, 1);
    test_op("msub_wrap", 3'b011, 32'd1, 32'd1, 34);
    test_op("madd_rand", 3'b010, $urandom, $urandom, 34);
    test_op("msub_rand", 3'b011, $urandom, $urandom, 34);
  endtask

  task automatic test_back_to_back();
    bit seen; int cyc, bcyc; logic [31:0] hi, lo; logic [63:0] e;
    issue(3'b000, 32'd2, 32'd3, 1);
    collect(60, seen, cyc, bcyc, hi, lo);
    e = sb.pop_front();
    checks++;
    if (!seen || {hi, lo} !== e) begin
      errors++;
      $display("FAIL b2b_first: done=%b hi/lo=%h_%h, want %h", seen, hi, lo, e);
    end
    issue(3'b010, 32'd4, 32'd5, 1);
    collect(60, seen, cyc, bcyc, hi, lo);
    e = sb.pop_front();
    checks++;
    if (!seen || cyc != 34 || {hi, lo} !== e || e !== 64'd26) begin
      errors++;
      $display("FAIL b2b_madd: done=%b cyc=%0d hi/lo=%h_%h, want 34 cycles and %h (26)", seen, cyc, hi, lo, e);
    end
  endtask

  task automatic test_ignored_start();
    bit seen; int cyc, bcyc, d; logic [31:0] hi, lo; logic [63:0] e;
    issue(3'b000, 32'd3, 32'd4, 1);
    repeat (9) @(posedge Clk);
    #1;
    Start = 1'b1; Op = 3'b000; A = 32'd5; B = 32'd5;
    @(posedge Clk);
    #1;
    Start = 1'b0; Op = 3'b111; A = '0; B = '0;
    collect(60, seen, cyc, bcyc, hi, lo);
    e = sb.pop_front();
    count_dones(45, d);
    checks++;
    if (!seen || {hi, lo} !== 64'd12 || e !== 64'd12 || d != 0) begin
      errors++;
      $display("FAIL ignored_start: done=%b hi/lo=%h_%h extra_dones=%0d, want 1, 0_c and 0", seen, hi, lo, d);
    end
  endtask

  task automatic test_idle_misc();
    int d;
    Flush = 1'b1;
    issue(3'b101, 32'hDEAD_BEEF, 32'd0, 0);
    Flush = 1'b0;
    issue(3'b110, 32'h1234_5678, 32'd9, 0);
    issue(3'b111, 32'h1234_5678, 32'd9, 0);
    count_dones(4, d);
    checks++;
    if (d != 0 || Busy !== 1'b0 || Hi !== mdl_hi || Lo !== mdl_lo) begin
      errors++;
      $display("FAIL idle_noop: dones=%0d busy=%b hi/lo=%h_%h, want 0 0 %h_%h", d, Busy, Hi, Lo, mdl_hi, mdl_lo);
    end
  endtask

  task automatic test_flush_reset();
    int d;
    test_op("mthi11", 3'b100, 32'h11, 32'd0, 1);
    test_op("mtlo22", 3'b101, 32'h22, 32'd0, 1);
    issue(3'b000, 32'd9, 32'd9, 0);
    repeat (14) @(posedge Clk);
    #1;
    Flush = 1'b1;
    @(posedge Clk);
    #1;
    Flush = 1'b0;
    @(negedge Clk);
    checks++;
    if (Busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: busy=%b, want 0", Busy);
    end
    count_dones(45, d);
    checks++;
    if (d != 0 || Hi !== 32'h11 || Lo !== 32'h22) begin
      errors++;
      $display("FAIL flush_state: dones=%0d hi/lo=%h_%h, want 0 00000011_00000022", d, Hi, Lo);
    end
    issue(3'b000, 32'd9, 32'd9, 0);
    repeat (19) @(posedge Clk);
    #1;
    Reset = 1'b0;
    #1;
    checks++;
    if ({Busy, Done, Hi, Lo} !== 66'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b hi/lo=%h_%h, want all 0", Busy, Done, Hi, Lo);
    end
    mdl_hi = '0; mdl_lo = '0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    count_dones(45, d);
    checks++;
    if (d != 0 || {Busy, Hi, Lo} !== 65'd0) begin
      errors++;
      $display("FAIL reset_after: dones=%0d busy=%b hi/lo=%h_%h, want 0 0 0_0", d, Busy, Hi, Lo);
    end
    test_op("post_reset", 3'b000, 32'd9, 32'd9, 34);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd_msub();
    test_back_to_back();
    test_ignored_start();
    test_idle_misc();
    test_flush_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hilo_mul_unit.md
# hilo_mul_unit

Multi-cycle multiply/accumulate unit that owns the architectural Hi/Lo register pair for the MIPS datapath. It executes mult, multu, madd, msub, mthi and mtlo, and drives the Hi/Lo values consumed by the ALU's Hi_in/Lo_in ports for mfhi/mflo. It sits beside the ALU in the execute stage. Busy is used by hazard logic to stall the pipeline while an iterative multiply is in flight.

## Interface
- No parameters. Operand width is fixed at 32 bits; the product is 64 bits.
- Clk  in  1  clock; all state updates on the rising edge.
- Reset  in  1  one clock; reset is asynchronous and active-low.
- Start  in  1  request; sampled only when Busy=0.
- Op  in  3  000 MULT, 001 MULTU, 010 MADD, 011 MSUB, 100 MTHI, 101 MTLO; 110/111 are no-ops.
- A  in  32  rs operand.
- B  in  32  rt operand.
- Flush  in  1  synchronous abort of an in-flight multiply.
- Busy  out  1  high while state is not IDLE (registered).
- Done  out  1  one-cycle completion pulse (registered).
- Hi  out  32  architectural Hi register; connects to ALU Hi_in.
- Lo  out  32  architectural Lo register; connects to ALU Lo_in.

## Operation
- States: IDLE, MUL, ACC.
- **IDLE**
  - Start=1, Flush=0, Op in {MULT, MULTU, MADD, MSUB}: latch the operation and operands and go to MUL.
    - For signed ops (MULT, MADD, MSUB), latch |A| and |B| as unsigned 32-bit values and latch neg = A[31]^B[31].
    - |0x80000000| = 0x80000000.
    - For MULTU, latch A and B unchanged with neg=0.
    - Clear the 64-bit accumulator P and the 5-bit counter.
  - Start=1, Op=MTHI: Hi<=A on that edge. Stay in IDLE.
  - Start=1, Op=MTLO: Lo<=A on that edge. Stay in IDLE.
  - Op 110/111: no effect and no Done.
- **MUL**: radix-2 shift-add, one multiplier bit per cycle.
  - If mcand bit[count] is 1, add the multiplier shifted left by count into P.
  - After count=31, go to ACC. MUL lasts exactly 32 cycles.
- **ACC**: form R = neg ? -P : P, modulo 2^64.
  - MULT/MULTU: {Hi,Lo} <= R.
  - MADD: {Hi,Lo} <= {Hi,Lo} + R.
  - MSUB: {Hi,Lo} <= {Hi,Lo} - R.
  - All accumulation wraps mod 2^64 with no overflow flag.
  - Then go to IDLE.
- **Done**: asserted for the one cycle after the edge that updates Hi/Lo. This applies to ACC completion and to the MTHI/MTLO write.
- **Flush**: when high in MUL or ACC, the next state is IDLE. Hi/Lo are unchanged and Done is not pulsed. Flush in IDLE overrides Start, and Start is ignored.
- **Start while Busy=1**: ignored; operands are not re-latched.
- **Reset**: Hi=0, Lo=0, Busy=0, Done=0, state=IDLE, P=0, counter=0. An asserted reset mid-operation discards the operation with no Hi/Lo update.

## Timing
- Accept edge k is the edge at which Start is sampled in IDLE.
- Multiply ops:
  - Busy=1 from after edge k until edge k+33.
  - Hi/Lo update at edge k+33.
  - Busy falls at edge k+33.
  - Done=1 during the cycle between edges k+33 and k+34.
- Back-to-back operation: a new Start may be accepted at edge k+34, i.e. in the cycle where Done=1. It then sees the updated Hi/Lo, which MADD/MSUB require.
- MTHI/MTLO: the write takes effect at edge k, Done is high for the following cycle, and Busy stays 0.
- Hi/Lo outputs come directly from registers with no combinational path from A/B. An mfhi in the cycle after Done observes the new value.

## Test plan
- Signed MULT: Reset, then MULT with A=0xFFFFFFFD (-3), B=7.
  - Busy high for exactly 33 cycles.
  - Then Hi=0xFFFFFFFF, Lo=0xFFFFFFEB, with a single Done pulse.
- MULTU and corner case:
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
  - MULT 0x80000000 × 0x80000000 -> Hi=0x40000000, Lo=0x00000000.
- MADD:
  - MTLO A=100 with Hi=0; check Done after 1 cycle and Lo=100.
  - Then MADD A=0xFFFFFFFE (-2), B=5 -> Hi=0, Lo=0x0000005A.
- MSUB wrap: with Hi/Lo=0, MSUB A=1, B=1 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFFF.
- Ignored Start: MULT 3×4, then at cycle 10 pulse Start with MULT 5×5.
  - Result is Hi=0, Lo=12.
  - Exactly one Done pulse.
- Flush and reset mid-operation:
  - Preload Hi=0x11, Lo=0x22 via MTHI/MTLO.
  - MULT 9×9 with Flush at cycle 15 -> Busy=0 the next cycle, no Done, Hi=0x11, Lo=0x22.
  - Repeat with Reset low at cycle 20 -> all outputs 0 immediately.
